seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: maximum pattern length in bits.
REQ-002 SHALL provide port clk, input, 1: single clock, all logic on rising edge.
REQ-003 SHALL provide port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL provide port start, input, 1: frame request, accepted only while ready=1.
REQ-005 SHALL provide port pattern, input, WIDTH: bits to transmit.
REQ-006 SHALL provide port len, input, $clog2(WIDTH+1): number of bits to send.
REQ-007 SHALL provide port ready, output, 1: high only in IDLE.
REQ-008 SHALL provide port x, output, 1: serial data bit.
REQ-009 SHALL provide port x_valid, output, 1: x carries a pattern bit this cycle.
REQ-010 SHALL provide port done, output, 1: one-cycle end-of-frame pulse.
REQ-011 SHALL register every output; no combinational input-to-output path.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE SHALL move to SHIFT when start=1 and len!=0 are sampled at an edge.
- pattern and len are captured at that same edge.
REQ-014 IDLE with start=1 and len=0 SHALL move directly to DONE: done pulses, no bits are sent.
REQ-015 len greater than WIDTH SHALL be clamped to WIDTH at capture.
REQ-016 With start accepted at edge k:
- bits appear on x in cycles k+1..k+L, where L is the captured length.
- order is pattern[L-1] first, down to pattern[0].
- x_valid=1 in exactly those cycles.
REQ-017 SHALL go SHIFT->DONE after the last bit; DONE lasts one cycle (done=1, x_valid=0, x=0), then IDLE.
REQ-018 start while not in IDLE SHALL be ignored; it is neither queued nor counted.
REQ-019 Changes to pattern or len after capture SHALL NOT affect the frame in flight.
REQ-020 Outside SHIFT, x SHALL be 0 and x_valid SHALL be 0.
REQ-021 Frame timing: ready falls in cycle k+1 and returns in cycle k+L+2.
- Back-to-back frames have a minimum 2-cycle gap between frames.

Reset
REQ-022 At a reset edge the FSM SHALL enter IDLE, including mid-frame, with any frame in flight abandoned.
- Outputs after the reset edge: ready=1, x=0, x_valid=0, done=0.
REQ-023 Reset SHALL take priority over start sampled at the same edge.
REQ-024 A frame abandoned by reset SHALL NOT produce a done pulse.

Configuration
REQ-025 Macro SEQ_TX_REPEAT_EN, when defined, SHALL add input port repeat (1 bit).
REQ-026 With the macro, repeat=1 sampled in the last SHIFT cycle SHALL restart the captured frame with no gap.
- In the following cycle, done=1 and x_valid=1, with x carrying the first bit again.
- The FSM stays in SHIFT.
REQ-027 Without the macro, the repeat port SHALL be absent and behaviour SHALL equal repeat=0.

Structure
REQ-028 Shared package seq_tx_pkg SHALL hold:
- the 2-bit state typedef: IDLE=0, SHIFT=1, DONE=2.
- the default WIDTH constant.
REQ-029 Sub-module seq_tx_shiftreg SHALL hold the WIDTH-bit load/shift register and the down-counter.
- Frame control stays in seq_pattern_tx.

Verification
REQ-030 pattern=8'b1011_0010, len=8, start at edge k:
- x=1,0,1,1,0,0,1,0 in cycles k+1..k+8.
- done=1 at k+9; ready=1 at k+10.
REQ-031 pattern=8'hFF, len=3:
- x_valid=1 for exactly 3 cycles, x=1,1,1.
- The upper bits are never emitted.
REQ-032 len=0 with start: no x_valid; done=1 at k+1; ready=1 at k+2.
REQ-033 start pulsed at k+3 during an 8-bit frame, and pattern changed at k+2:
- output is unchanged from REQ-030.
- exactly one done pulse.
REQ-034 reset asserted at k+4 of an 8-bit frame:
- cycle k+5 shows ready=1, x_valid=0, done=0.
- no done pulse follows.
REQ-035 With SEQ_TX_REPEAT_EN, repeat=1, pattern=4'b1001, len=4:
- x=1,0,0,1,1,0,0,1 is continuous.
- done=1 on the 5th bit cycle.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared state encoding and default width for the pattern transmitter
package seq_tx_pkg;

    localparam int SEQ_TX_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_tx_state_e;

endpackage

// File: rtl/seq_tx_shiftreg.sv
// rtl/seq_tx_shiftreg.sv - MSB-first load/shift register with captured frame copy and bit down-counter
module seq_tx_shiftreg
    import seq_tx_pkg::*;
#(
    parameter  int WIDTH = SEQ_TX_WIDTH,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             next_msb,
    output logic [LW-1:0]    cnt
);

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] pat_q,  pat_d;
    logic [LW-1:0]    len_q,  len_d;
    logic [LW-1:0]    cnt_q,  cnt_d;

    // Left-align the frame so bit len-1 sits at the MSB; the MSB is always the bit on the wire.
    always_comb begin
        data_d = data_q;
        pat_d  = pat_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (load) begin
            pat_d  = pattern;
            len_d  = len;
            data_d = pattern << (WIDTH_L - len);
            cnt_d  = len;
        end else if (reload) begin
            data_d = pat_q << (WIDTH_L - len_q);
            cnt_d  = len_q;
        end else if (shift) begin
            data_d = data_q << 1;
            cnt_d  = cnt_q - LW'(1);
        end
    end

    // Register storage; the captured copy lets a repeated frame restart after shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    assign next_msb = data_d[WIDTH-1];
    assign cnt      = cnt_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, IDLE/SHIFT/DONE frame control
// Optional: SEQ_TX_REPEAT_EN adds input repeat_i (repeat is a reserved word) for gapless frame restart.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter  int WIDTH = SEQ_TX_WIDTH,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
`ifdef SEQ_TX_REPEAT_EN
    input  logic             repeat_i,
`endif
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

    seq_tx_state_e state_q, state_d;

    logic [LW-1:0] len_c;
    logic [LW-1:0] sr_cnt;
    logic          sr_next_msb;
    logic          rpt;
    logic          last_bit;
    logic          load;
    logic          restart;
    logic          shift;

    logic ready_q,   ready_d;
    logic x_q,       x_d;
    logic x_valid_q, x_valid_d;
    logic done_q,    done_d;

`ifdef SEQ_TX_REPEAT_EN
    assign rpt = repeat_i;
`else
    assign rpt = 1'b0;
`endif

    // Clamp the requested length and derive the shift-register controls from the current state.
    always_comb begin
        len_c    = (len > WIDTH_L) ? WIDTH_L : len;
        last_bit = (sr_cnt == LW'(1));
        load     = (state_q == IDLE)  && start && (len_c != '0);
        restart  = (state_q == SHIFT) && last_bit && rpt;
        shift    = (state_q == SHIFT) && !last_bit;
    end

    seq_tx_shiftreg #(
        .WIDTH (WIDTH)
    ) u_shiftreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .reload   (restart),
        .shift    (shift),
        .pattern  (pattern),
        .len      (len_c),
        .next_msb (sr_next_msb),
        .cnt      (sr_cnt)
    );

    // State register; reset wins over any start sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_c != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_bit && !rpt) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        ready_d   = (state_d == IDLE);
        x_valid_d = (state_d == SHIFT);
        x_d       = (state_d == SHIFT) ? sr_next_msb : 1'b0;
        done_d    = (state_d == DONE) || restart;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b1;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
`ifdef SEQ_TX_REPEAT_EN
    logic       repeat_i = 1'b0;
`endif
    logic       ready;
    logic       x;
    logic       x_valid;
    logic       done;

    int pass_cnt  = 0;
    int check_cnt = 0;

    seq_pattern_tx #(
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
`ifdef SEQ_TX_REPEAT_EN
        .repeat_i (repeat_i),
`endif
        .ready    (ready),
        .x        (x),
        .x_valid  (x_valid),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int ncyc, output logic [31:0] bits, output int nvalid, output int ndone);
        bits   = '0;
        nvalid = 0;
        ndone  = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (x_valid) begin
                bits = {bits[30:0], x};
                nvalid++;
            end
            if (done) ndone++;
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b1000)
            $display("FAIL reset_outputs: got %b want 1000", {ready, x_valid, done, x});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b1000)
            $display("FAIL reset_idle_hold: got %b want 1000", {ready, x_valid, done, x});
        else pass_cnt++;
    endtask

    task automatic test_full_frame;
        logic [7:0] exp;
        exp     = 8'b1011_0010;
        pattern = exp;
        len     = 4'd8;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            check_cnt++;
            if ({ready, x_valid, done, x} !== {3'b010, exp[i]})
                $display("FAIL full_bit%0d: got %b want %b", 7 - i, {ready, x_valid, done, x}, {3'b010, exp[i]});
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b0010)
            $display("FAIL full_done: got %b want 0010", {ready, x_valid, done, x});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b1000)
            $display("FAIL full_ready: got %b want 1000", {ready, x_valid, done, x});
        else pass_cnt++;
    endtask

    task automatic test_short_and_clamp;
        logic [31:0] bits;
        int          nvalid;
        int          ndone;
        pattern = 8'hFF;
        len     = 4'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        capture(12, bits, nvalid, ndone);
        check_cnt++;
        if (nvalid !== 3 || bits !== 32'h7 || ndone !== 1)
            $display("FAIL short_len3: got valid=%0d bits=%h done=%0d want valid=3 bits=7 done=1", nvalid, bits, ndone);
        else pass_cnt++;
        pattern = 8'hB2;
        len     = 4'd15;
        start   = 1'b1;
        tick();
        start = 1'b0;
        capture(14, bits, nvalid, ndone);
        check_cnt++;
        if (nvalid !== 8 || bits !== 32'hB2 || ndone !== 1)
            $display("FAIL clamp_len15: got valid=%0d bits=%h done=%0d want valid=8 bits=b2 done=1", nvalid, bits, ndone);
        else pass_cnt++;
    endtask

    task automatic test_len_zero;
        pattern = 8'hFF;
        len     = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b0010)
            $display("FAIL len0_done: got %b want 0010", {ready, x_valid, done, x});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b1000)
            $display("FAIL len0_ready: got %b want 1000", {ready, x_valid, done, x});
        else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        logic [31:0] bits;
        int          nvalid;
        int          ndone;
        bits    = '0;
        nvalid  = 0;
        ndone   = 0;
        pattern = 8'hB2;
        len     = 4'd8;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (x_valid) begin
                bits = {bits[30:0], x};
                nvalid++;
            end
            if (done) ndone++;
            if (c == 2) begin
                pattern = 8'h00;
                len     = 4'd3;
            end
            start = (c == 3);
            tick();
        end
        start = 1'b0;
        check_cnt++;
        if (nvalid !== 8 || bits !== 32'hB2 || ndone !== 1)
            $display("FAIL ignore_start: got valid=%0d bits=%h done=%0d want valid=8 bits=b2 done=1", nvalid, bits, ndone);
        else pass_cnt++;
        check_cnt++;
        if (ready !== 1'b1)
            $display("FAIL ignore_start_ready: got %b want 1", ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] bits;
        int          nvalid;
        int          ndone;
        pattern = 8'hB2;
        len     = 4'd8;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b1000)
            $display("FAIL reset_mid_state: got %b want 1000", {ready, x_valid, done, x});
        else pass_cnt++;
        capture(12, bits, nvalid, ndone);
        check_cnt++;
        if (nvalid !== 0 || ndone !== 0)
            $display("FAIL reset_mid_quiet: got valid=%0d done=%0d want valid=0 done=0", nvalid, ndone);
        else pass_cnt++;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b1000)
            $display("FAIL reset_priority: got %b want 1000", {ready, x_valid, done, x});
        else pass_cnt++;
        capture(12, bits, nvalid, ndone);
        check_cnt++;
        if (nvalid !== 0 || ndone !== 0)
            $display("FAIL reset_priority_quiet: got valid=%0d done=%0d want valid=0 done=0", nvalid, ndone);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] r, v, d, xs;
        pattern = 8'hA5;
        len     = 4'd2;
        start   = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            r[7-c]  = ready;
            v[7-c]  = x_valid;
            d[7-c]  = done;
            xs[7-c] = x;
            tick();
        end
        start = 1'b0;
        check_cnt++;
        if (v !== 8'b1100_1100 || d !== 8'b0010_0010)
            $display("FAIL b2b_valid_done: got valid=%b done=%b want 11001100 00100010", v, d);
        else pass_cnt++;
        check_cnt++;
        if (r !== 8'b0001_0001 || xs !== 8'b0100_0100)
            $display("FAIL b2b_ready_x: got ready=%b x=%b want 00010001 01000100", r, xs);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) tick();
    endtask

`ifdef SEQ_TX_REPEAT_EN
    task automatic test_repeat;
        logic [7:0] v, d, xs;
        pattern  = 8'h09;
        len      = 4'd4;
        repeat_i = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            v[8-c]  = x_valid;
            d[8-c]  = done;
            xs[8-c] = x;
            if (c == 5) repeat_i = 1'b0;
            tick();
        end
        check_cnt++;
        if (v !== 8'hFF || xs !== 8'b1001_1001 || d !== 8'b0000_1000)
            $display("FAIL repeat_stream: got valid=%b x=%b done=%b want 11111111 10011001 00001000", v, xs, d);
        else pass_cnt++;
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b0010)
            $display("FAIL repeat_end_done: got %b want 0010", {ready, x_valid, done, x});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({ready, x_valid, done, x} !== 4'b1000)
            $display("FAIL repeat_end_ready: got %b want 1000", {ready, x_valid, done, x});
        else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_short_and_clamp();
        test_len_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SEQ_TX_REPEAT_EN
        test_repeat();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
